phys_free_list: RTL and testbench

// Circular free list of physical register tags, feeding the rename stage.
// - Rename pops one free preg per renamed instruction that writes rd.
// - ROB retire pushes back the old (pd_old) mapping.
// - Branch checkpoints save the read pointer. Mispredict recovery restores it,

---
 rtl/phys_free_list.sv | 164 ++++++++++++++++
 tb/tb_phys_free_list.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// phys_free_list: circular free list of physical register tags for rename.
// Pops feed rename, retire pushes pd_old back, branch checkpoints save the
// read pointer so a mispredict returns wrong-path tags in one cycle.
// Optional macro FREE_LIST_DUP_CHECK_EN adds an is_free vector that drops
// double-frees and pulses err_double_free.
module phys_free_list #(
    parameter int unsigned NUM_PREGS  = 128,
    parameter int unsigned NUM_AREGS  = 32,
    parameter int unsigned CKPT_DEPTH = 4,
    localparam int unsigned PW = $clog2(NUM_PREGS),
    localparam int unsigned CW = $clog2(CKPT_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    output logic          alloc_ready,
    output logic [PW-1:0] alloc_preg,
    input  logic          release_valid,
    input  logic [PW-1:0] release_preg,
    input  logic          ckpt_save,
    input  logic [CW-1:0] ckpt_id,
    input  logic          restore,
    input  logic [CW-1:0] restore_id,
    output logic [PW-1:0] free_count,
    output logic          err_double_free
);

    localparam int unsigned DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SW    = AW + 1;

    logic [PW-1:0] mem_q  [DEPTH];
    logic [PW-1:0] mem_d  [DEPTH];
    logic [AW-1:0] ckpt_q [CKPT_DEPTH];
    logic [AW-1:0] ckpt_d [CKPT_DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [PW-1:0] count_q, count_d;

    logic          pop_c;
    logic          push_c;
    logic          dup_c;
    logic [AW-1:0] saved_c;
    logic [AW-1:0] rollback_c;

    // Pointer increment with explicit wrap (DEPTH is not a power of two).
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Forward distance from b to a around the ring.
    function automatic logic [AW-1:0] ptr_dist(input logic [AW-1:0] a, input logic [AW-1:0] b);
        if (a >= b) begin
            return a - b;
        end
        return AW'(SW'(a) + SW'(DEPTH) - SW'(b));
    endfunction

    assign alloc_ready = (count_q != '0);
    assign alloc_preg  = mem_q[head_q];
    assign free_count  = count_q;

    assign saved_c    = ckpt_q[restore_id];
    assign rollback_c = ptr_dist(head_q, saved_c);
    assign pop_c      = alloc_req && alloc_ready && !restore;

`ifdef FREE_LIST_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] is_free_q, is_free_d;
    logic                 err_q, err_d;

    // Accept a push only for a non-zero tag that is not already free.
    always_comb begin
        dup_c  = release_valid && (release_preg != '0) && is_free_q[release_preg];
        push_c = release_valid && (release_preg != '0) && !is_free_q[release_preg];
    end

    // Track freeness: pop clears, push sets, restore rebuilds rolled-back range.
    always_comb begin
        is_free_d = is_free_q;
        err_d     = dup_c;
        if (pop_c) begin
            is_free_d[mem_q[head_q]] = 1'b0;
        end
        if (restore) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ptr_dist(AW'(i), saved_c) < rollback_c) begin
                    is_free_d[mem_q[i]] = 1'b1;
                end
            end
        end
        if (push_c) begin
            is_free_d[release_preg] = 1'b1;
        end
    end

    // Duplicate-check state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_free_q <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
            err_q     <= 1'b0;
        end else begin
            is_free_q <= is_free_d;
            err_q     <= err_d;
        end
    end

    assign err_double_free = err_q;
`else
    // Without the duplicate check every non-zero release is accepted.
    always_comb begin
        dup_c  = 1'b0;
        push_c = release_valid && (release_preg != '0);
    end

    assign err_double_free = dup_c;
`endif

    // Next-state for ring storage, pointers, count and checkpoints.
    always_comb begin
        mem_d   = mem_q;
        ckpt_d  = ckpt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_c) begin
            mem_d[tail_q] = release_preg;
            tail_d        = ptr_inc(tail_q);
        end
        if (restore) begin
            head_d  = saved_c;
            count_d = count_q + PW'(rollback_c) + PW'(push_c);
        end else begin
            if (pop_c) begin
                head_d = ptr_inc(head_q);
            end
            count_d = count_q + PW'(push_c) - PW'(pop_c);
            if (ckpt_save) begin
                ckpt_d[ckpt_id] = head_d;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PW'(NUM_AREGS + i);
            end
            for (int unsigned j = 0; j < CKPT_DEPTH; j++) begin
                ckpt_q[j] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= PW'(DEPTH);
        end else begin
            mem_q   <= mem_d;
            ckpt_q  <= ckpt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list: directed scenarios plus randomized traffic against a
// queue-based model of the free list (free tags in order, allocation log,
// checkpoints as allocation-log positions).
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic       alloc_ready;
    logic [6:0] alloc_preg;
    logic       release_valid;
    logic [6:0] release_preg;
    logic       ckpt_save;
    logic [1:0] ckpt_id;
    logic       restore;
    logic [1:0] restore_id;
    logic [6:0] free_count;
    logic       err;

    phys_free_list dut (
        .clk            (clk),
        .reset          (reset),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_preg     (alloc_preg),
        .release_valid  (release_valid),
        .release_preg   (release_preg),
        .ckpt_save      (ckpt_save),
        .ckpt_id        (ckpt_id),
        .restore        (restore),
        .restore_id     (restore_id),
        .free_count     (free_count),
        .err_double_free(err)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // Model state
    int free_q[$];
    int log_q[$];
    int held[$];
    int ck_seq[4];
    bit ck_val[4];
    bit exp_err;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        log_q.delete();
        held.delete();
        for (int i = 32; i < 128; i++) free_q.push_back(i);
        for (int i = 1; i < 32; i++) held.push_back(i);
        for (int i = 0; i < 4; i++) begin
            ck_seq[i] = 0;
            ck_val[i] = 1'b0;
        end
        exp_err = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit rv, input int rp, input bit cs,
                              input int cid, input bit rs, input int rid);
        bit do_push;
        bit dup;
        bit do_pop;
        int s;
        do_push = rv && (rp != 0);
        dup     = 1'b0;
`ifdef FREE_LIST_DUP_CHECK_EN
        if (do_push) begin
            foreach (free_q[k]) if (free_q[k] == rp) dup = 1'b1;
            if (dup) do_push = 1'b0;
        end
`endif
        do_pop = a && (free_q.size() != 0) && !rs;
        if (rs) begin
            s = ck_seq[rid];
            while (log_q.size() > s) free_q.push_front(log_q.pop_back());
            for (int i = 0; i < 4; i++) if (ck_seq[i] > s) ck_val[i] = 1'b0;
        end else begin
            if (do_pop) log_q.push_back(free_q.pop_front());
            if (cs) begin
                ck_seq[cid] = log_q.size();
                ck_val[cid] = 1'b1;
            end
        end
        if (do_push) free_q.push_back(rp);
        exp_err = dup;
    endtask

    // Speculative allocations become architectural; checkpoints retire.
    task automatic commit();
        while (log_q.size() != 0) held.push_back(log_q.pop_front());
        for (int i = 0; i < 4; i++) ck_val[i] = 1'b0;
    endtask

    // Called at a negedge: drive, clock, update model, return at next negedge.
    task automatic cycle(input bit a, input bit rv, input int rp, input bit cs,
                         input int cid, input bit rs, input int rid);
        alloc_req     = a;
        release_valid = rv;
        release_preg  = 7'(rp);
        ckpt_save     = cs;
        ckpt_id       = 2'(cid);
        restore       = rs;
        restore_id    = 2'(rid);
        @(posedge clk);
        model_step(a, rv, rp, cs, cid, rs, rid);
        @(negedge clk);
    endtask

    task automatic do_reset();
        chk_en        = 1'b0;
        reset         = 1'b1;
        alloc_req     = 1'b0;
        release_valid = 1'b0;
        release_preg  = '0;
        ckpt_save     = 1'b0;
        ckpt_id       = '0;
        restore       = 1'b0;
        restore_id    = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", int'(alloc_ready), int'(free_q.size() != 0));
            check("count", int'(free_count), free_q.size());
            if (free_q.size() != 0) check("preg", int'(alloc_preg), free_q[0]);
            check("err", int'(err), int'(exp_err));
        end
    end

    initial begin
        int idx;
        int rp;
        int cid;
        int rid;
        bit a;
        bit rv;
        bit cs;
        bit rs;

        @(negedge clk);
        do_reset();
        // T1
        check("t1_ready", int'(alloc_ready), 1);
        check("t1_preg", int'(alloc_preg), 32);
        check("t1_count", int'(free_count), 96);

        // T2: drain
        for (int i = 0; i < 96; i++) begin
            if (i == 95) check("t2_last_preg", int'(alloc_preg), 127);
            cycle(1, 0, 0, 0, 0, 0, 0);
        end
        check("t2_ready", int'(alloc_ready), 0);
        check("t2_count", int'(free_count), 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("t2_extra_count", int'(free_count), 0);

        // T3: release into empty list, no bypass
        cycle(0, 1, 40, 0, 0, 0, 0);
        check("t3_ready", int'(alloc_ready), 1);
        check("t3_preg", int'(alloc_preg), 40);
        check("t3_count", int'(free_count), 1);

        // Reset while requests are active
        alloc_req = 1'b1;
        do_reset();
        check("rst_count", int'(free_count), 96);

        // T4
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        check("t4_pre_count", int'(free_count), 87);
        cycle(0, 0, 0, 0, 0, 1, 2);
        check("t4_preg", int'(alloc_preg), 38);
        check("t4_count", int'(free_count), 90);

        // T5: restore with same-cycle release and alloc_req
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < held.size(); i++) if (held[i] == 7) begin held.delete(i); break; end
        cycle(1, 1, 7, 1, 1, 1, 2);
        check("t5_preg", int'(alloc_preg), 38);
        check("t5_count", int'(free_count), 91);

        // T6: drain, refill with wrap, FIFO order checked every cycle
        do_reset();
        for (int i = 0; i < 96; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        commit();
        for (int i = 0; i < 96; i++) begin
            if (i == 40) cycle(0, 1, 0, 0, 0, 0, 0);
            idx = $urandom_range(held.size() - 1);
            rp  = held[idx];
            held.delete(idx);
            cycle(0, 1, rp, 0, 0, 0, 0);
        end
        check("t6_count", int'(free_count), 96);
`ifdef FREE_LIST_DUP_CHECK_EN
        rp = free_q[10];
        cycle(0, 1, rp, 0, 0, 0, 0);
        check("t6_dup_err", int'(err), 1);
        check("t6_dup_count", int'(free_count), 96);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("t6_dup_pulse", int'(err), 0);
`endif
        for (int i = 0; i < 96; i++) cycle(1, 0, 0, 0, 0, 0, 0);
        check("t6_empty", int'(alloc_ready), 0);
        commit();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            a  = ($urandom % 4) != 0;
            rv = 1'b0;
            rp = 0;
            if ((free_q.size() + log_q.size() < 96) && ($urandom % 2 == 1)) begin
                idx = $urandom_range(held.size() - 1);
                rp  = held[idx];
                held.delete(idx);
                rv  = 1'b1;
            end else if ($urandom % 16 == 0) begin
                rv = 1'b1;
            end
            rid = $urandom % 4;
            rs  = ($urandom % 10 == 0) && ck_val[rid];
            if (!rs && ($urandom % 25 == 0)) commit();
            cs  = ($urandom % 6) == 0;
            cid = $urandom % 4;
            cycle(a, rv, rp, cs, cid, rs, rid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
